data_req_ctrl: RTL and testbench

- Data-side request controller between EX and MEM; owns the SRAM-like req/addr_ok/data_ok handshake to the data cache.
- Issues the memory request of the EX-stage instruction and tracks outstanding requests.
- Discards responses belonging to flushed instructions.
- Buffers early responses so the MEM stage sees exactly one data_ok and rdata per valid access.

---
 rtl/data_req_ctrl.sv | 129 ++++++++++++
 tb/tb_data_req_ctrl.sv | 530 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_req_ctrl.sv
// Data-side request controller: issues EX memory requests to the dcache,
// tracks outstanding/cancelled responses and buffers early read data.
module data_req_ctrl #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_req_valid_i,
  input  logic              ex_wr_i,
  input  logic [1:0]        ex_size_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              mem_allowin_i,
  input  logic              mem_wait_i,
  input  logic              excep_flush_i,
  output logic              ex_ready_go_o,
  output logic              data_sram_req_o,
  output logic              data_sram_wr_o,
  output logic [1:0]        data_sram_size_o,
  output logic [3:0]        data_sram_wstrb_o,
  output logic [ADDR_W-1:0] data_sram_addr_o,
  output logic [DATA_W-1:0] data_sram_wdata_o,
  input  logic              data_sram_addr_ok_i,
  input  logic              data_sram_data_ok_i,
  input  logic [DATA_W-1:0] data_sram_rdata_i,
  output logic              mem_data_ok_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              busy_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     cancel_cnt;
  logic [CW-1:0]     out_next;
  logic              issued;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;
  logic              req;
  logic              accept;
  logic              live;
  logic              run;
  logic [3:0]        wstrb;

  // rst_n is active-high; outputs are held at zero while it is asserted
  assign run = ~rst_n;

  assign req = ex_req_valid_i & ~issued & ~excep_flush_i
             & (outstanding < CW'(MAX_OUTSTANDING));
  assign accept   = req & data_sram_addr_ok_i;
  assign live     = data_sram_data_ok_i & (cancel_cnt == '0);
  assign out_next = outstanding + CW'(accept)
                  - CW'(data_sram_data_ok_i);

  always_comb begin
    wstrb = 4'b0000;
    if (ex_wr_i) begin
      if (ex_size_i == 2'd0)
        wstrb = 4'b0001 << ex_addr_i[1:0];
      else if (ex_size_i == 2'd1)
        wstrb = 4'b0011 << ex_addr_i[1:0];
      else
        wstrb = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      issued      <= 1'b0;
      outstanding <= '0;
      cancel_cnt  <= '0;
      buf_valid   <= 1'b0;
      buf_data    <= '0;
    end else begin
      if (mem_allowin_i | excep_flush_i)
        issued <= 1'b0;
      else if (accept)
        issued <= 1'b1;

      outstanding <= out_next;

      // on flush every still-pending response becomes a discard
      if (excep_flush_i)
        cancel_cnt <= out_next;
      else if (data_sram_data_ok_i && cancel_cnt != '0)
        cancel_cnt <= cancel_cnt - 1'b1;

      if (excep_flush_i) begin
        buf_valid <= 1'b0;
      end else if (buf_valid) begin
        if (mem_wait_i)
          buf_valid <= 1'b0;
      end else if (live && !mem_wait_i) begin
        buf_valid <= 1'b1;
        buf_data  <= data_sram_rdata_i;
      end
    end
  end

  assign data_sram_req_o   = run & req;
  assign data_sram_wr_o    = run & ex_wr_i;
  assign data_sram_size_o  = run ? ex_size_i : 2'd0;
  assign data_sram_wstrb_o = run ? wstrb : 4'd0;
  assign data_sram_addr_o  = run ? ex_addr_i : '0;
  assign data_sram_wdata_o = run ? ex_wdata_i : '0;

  assign ex_ready_go_o = run & (~ex_req_valid_i | issued | accept);

  assign mem_data_ok_o = run & mem_wait_i & (buf_valid | live);

  always_comb begin
    mem_rdata_o = '0;
    if (run) begin
      if (buf_valid)
        mem_rdata_o = buf_data;
      else if (live && mem_wait_i)
        mem_rdata_o = data_sram_rdata_i;
    end
  end

  assign busy_o = run & ((outstanding != '0) | (cancel_cnt != '0));

  a_no_live_over_buf: assert property (
    @(posedge clk) disable iff (rst_n)
    !(live && buf_valid && !excep_flush_i));

endmodule

// File: tb/tb_data_req_ctrl.sv
// Self-checking bench for data_req_ctrl: directed scenarios plus a
// randomized run against a queue-based response model.
module tb_data_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_req_valid_i;
  logic        ex_wr_i;
  logic [1:0]  ex_size_i;
  logic [31:0] ex_addr_i;
  logic [31:0] ex_wdata_i;
  logic        mem_allowin_i;
  logic        mem_wait_i;
  logic        excep_flush_i;
  logic        ex_ready_go_o;
  logic        data_sram_req_o;
  logic        data_sram_wr_o;
  logic [1:0]  data_sram_size_o;
  logic [3:0]  data_sram_wstrb_o;
  logic [31:0] data_sram_addr_o;
  logic [31:0] data_sram_wdata_o;
  logic        data_sram_addr_ok_i;
  logic        data_sram_data_ok_i;
  logic [31:0] data_sram_rdata_i;
  logic        mem_data_ok_o;
  logic [31:0] mem_rdata_o;
  logic        busy_o;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    bit          cancel;
  } ent_t;

  data_req_ctrl #(
    .MAX_OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex_req_valid_i(ex_req_valid_i),
    .ex_wr_i(ex_wr_i),
    .ex_size_i(ex_size_i),
    .ex_addr_i(ex_addr_i),
    .ex_wdata_i(ex_wdata_i),
    .mem_allowin_i(mem_allowin_i),
    .mem_wait_i(mem_wait_i),
    .excep_flush_i(excep_flush_i),
    .ex_ready_go_o(ex_ready_go_o),
    .data_sram_req_o(data_sram_req_o),
    .data_sram_wr_o(data_sram_wr_o),
    .data_sram_size_o(data_sram_size_o),
    .data_sram_wstrb_o(data_sram_wstrb_o),
    .data_sram_addr_o(data_sram_addr_o),
    .data_sram_wdata_o(data_sram_wdata_o),
    .data_sram_addr_ok_i(data_sram_addr_ok_i),
    .data_sram_data_ok_i(data_sram_data_ok_i),
    .data_sram_rdata_i(data_sram_rdata_i),
    .mem_data_ok_o(mem_data_ok_o),
    .mem_rdata_o(mem_rdata_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ex_req_valid_i      = 1'b0;
    ex_wr_i             = 1'b0;
    ex_size_i           = 2'd0;
    ex_addr_i           = '0;
    ex_wdata_i          = '0;
    mem_allowin_i       = 1'b1;
    mem_wait_i          = 1'b0;
    excep_flush_i       = 1'b0;
    data_sram_addr_ok_i = 1'b0;
    data_sram_data_ok_i = 1'b0;
    data_sram_rdata_i   = '0;
  endtask

  task automatic load(input logic [31:0] a);
    ex_req_valid_i = 1'b1;
    ex_wr_i        = 1'b0;
    ex_size_i      = 2'd2;
    ex_addr_i      = a;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b1;
    load(32'h40);
    data_sram_addr_ok_i = 1'b1;
    mem_wait_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (data_sram_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req got %0b exp 0", data_sram_req_o);
    end
    n_chk++;
    if (ex_ready_go_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got %0b exp 0", ex_ready_go_o);
    end
    n_chk++;
    if ({mem_data_ok_o, busy_o, data_sram_addr_o} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outs got %0h exp 0",
               {mem_data_ok_o, busy_o, data_sram_addr_o});
    end
    @(negedge clk);
    idle();
    rst_n = 1'b0;
  endtask

  task automatic test_load_word();
    @(negedge clk);
    load(32'h1000);
    data_sram_addr_ok_i = 1'b1;
    #1;
    n_chk++;
    if ({data_sram_req_o, data_sram_wstrb_o, ex_ready_go_o} !== 6'b1_0000_1) begin
      n_fail++;
      $display("FAIL lw_req got req=%0b wstrb=%b rdy=%0b exp 1 0000 1",
               data_sram_req_o, data_sram_wstrb_o, ex_ready_go_o);
    end
    n_chk++;
    if (data_sram_addr_o !== 32'h1000 || data_sram_size_o !== 2'd2) begin
      n_fail++;
      $display("FAIL lw_addr got %h/%0d exp 1000/2",
               data_sram_addr_o, data_sram_size_o);
    end
    @(negedge clk);
    idle();
    mem_wait_i = 1'b1;
    #1;
    n_chk++;
    if (data_sram_req_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_wait got req=%0b busy=%0b exp 0 1",
               data_sram_req_o, busy_o);
    end
    @(negedge clk);
    data_sram_data_ok_i = 1'b1;
    data_sram_rdata_i   = 32'hDEADBEEF;
    #1;
    n_chk++;
    if (mem_data_ok_o !== 1'b1 || mem_rdata_o !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lw_data got %0b/%h exp 1/deadbeef",
               mem_data_ok_o, mem_rdata_o);
    end
    @(negedge clk);
    idle();
    #1;
    n_chk++;
    if (busy_o !== 1'b0 || mem_data_ok_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_done got busy=%0b dok=%0b exp 0 0",
               busy_o, mem_data_ok_o);
    end
  endtask

  task automatic test_store_stall();
    int nreq = 0;
    @(negedge clk);
    ex_req_valid_i = 1'b1;
    ex_wr_i        = 1'b1;
    ex_size_i      = 2'd0;
    ex_addr_i      = 32'h1003;
    ex_wdata_i     = 32'hA5A5A5A5;
    mem_allowin_i  = 1'b0;
    data_sram_addr_ok_i = 1'b1;
    #1;
    n_chk++;
    if ({data_sram_wstrb_o, data_sram_size_o, data_sram_wr_o} !== 7'b1000_00_1) begin
      n_fail++;
      $display("FAIL sb_fields got wstrb=%b size=%0d wr=%0b exp 1000 0 1",
               data_sram_wstrb_o, data_sram_size_o, data_sram_wr_o);
    end
    n_chk++;
    if (data_sram_wdata_o !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL sb_wdata got %h exp a5a5a5a5", data_sram_wdata_o);
    end
    nreq += int'(data_sram_req_o & data_sram_addr_ok_i);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_allowin_i = (i == 2);
      #1;
      nreq += int'(data_sram_req_o & data_sram_addr_ok_i);
      n_chk++;
      if (data_sram_req_o !== 1'b0 || ex_ready_go_o !== 1'b1) begin
        n_fail++;
        $display("FAIL sb_stall%0d got req=%0b rdy=%0b exp 0 1",
                 i, data_sram_req_o, ex_ready_go_o);
      end
    end
    n_chk++;
    if (nreq !== 1) begin
      n_fail++;
      $display("FAIL sb_count got %0d exp 1", nreq);
    end
    @(negedge clk);
    idle();
    mem_wait_i = 1'b1;
    data_sram_data_ok_i = 1'b1;
    #1;
    n_chk++;
    if (mem_data_ok_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_resp got %0b exp 1", mem_data_ok_o);
    end
    @(negedge clk);
    idle();
    #1;
    n_chk++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_idle got busy=%0b exp 0", busy_o);
    end
  endtask

  task automatic test_flush_cancel();
    @(negedge clk);
    load(32'h2000);
    data_sram_addr_ok_i = 1'b1;
    @(negedge clk);
    idle();
    mem_wait_i    = 1'b1;
    excep_flush_i = 1'b1;
    #1;
    n_chk++;
    if (data_sram_req_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_flush got req=%0b busy=%0b exp 0 1",
               data_sram_req_o, busy_o);
    end
    @(negedge clk);
    idle();
    data_sram_data_ok_i = 1'b1;
    data_sram_rdata_i   = 32'h55;
    #1;
    n_chk++;
    if (mem_data_ok_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_drop got dok=%0b busy=%0b exp 0 1",
               mem_data_ok_o, busy_o);
    end
    @(negedge clk);
    idle();
    mem_wait_i = 1'b1;
    #1;
    n_chk++;
    if (mem_data_ok_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_after got dok=%0b busy=%0b exp 0 0",
               mem_data_ok_o, busy_o);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h11;
    exp_d[1] = 32'h22;
    exp_d[2] = 32'h33;
    @(negedge clk);
    load(32'h3000);
    data_sram_addr_ok_i = 1'b1;
    @(negedge clk);
    load(32'h3004);
    mem_wait_i = 1'b1;
    #1;
    n_chk++;
    if (data_sram_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second got %0b exp 1", data_sram_req_o);
    end
    @(negedge clk);
    load(32'h3008);
    mem_allowin_i = 1'b0;
    #1;
    n_chk++;
    if (data_sram_req_o !== 1'b0 || ex_ready_go_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full got req=%0b rdy=%0b exp 0 0",
               data_sram_req_o, ex_ready_go_o);
    end
    @(negedge clk);
    data_sram_addr_ok_i = 1'b0;
    data_sram_data_ok_i = 1'b1;
    data_sram_rdata_i   = exp_d[0];
    #1;
    n_chk++;
    if (data_sram_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_still got %0b exp 0", data_sram_req_o);
    end
    n_chk++;
    if (mem_data_ok_o !== 1'b1 || mem_rdata_o !== exp_d[0]) begin
      n_fail++;
      $display("FAIL b2b_r0 got %0b/%h exp 1/%h",
               mem_data_ok_o, mem_rdata_o, exp_d[0]);
    end
    @(negedge clk);
    data_sram_addr_ok_i = 1'b1;
    mem_allowin_i       = 1'b1;
    data_sram_rdata_i   = exp_d[1];
    #1;
    n_chk++;
    if (data_sram_req_o !== 1'b1 || ex_ready_go_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_third got req=%0b rdy=%0b exp 1 1",
               data_sram_req_o, ex_ready_go_o);
    end
    n_chk++;
    if (mem_data_ok_o !== 1'b1 || mem_rdata_o !== exp_d[1]) begin
      n_fail++;
      $display("FAIL b2b_r1 got %0b/%h exp 1/%h",
               mem_data_ok_o, mem_rdata_o, exp_d[1]);
    end
    @(negedge clk);
    idle();
    mem_wait_i = 1'b1;
    data_sram_data_ok_i = 1'b1;
    data_sram_rdata_i   = exp_d[2];
    #1;
    n_chk++;
    if (mem_data_ok_o !== 1'b1 || mem_rdata_o !== exp_d[2]) begin
      n_fail++;
      $display("FAIL b2b_r2 got %0b/%h exp 1/%h",
               mem_data_ok_o, mem_rdata_o, exp_d[2]);
    end
    @(negedge clk);
    idle();
    #1;
    n_chk++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle got busy=%0b exp 0", busy_o);
    end
  endtask

  task automatic test_buffer();
    @(negedge clk);
    load(32'h4000);
    mem_allowin_i = 1'b0;
    data_sram_addr_ok_i = 1'b1;
    @(negedge clk);
    data_sram_addr_ok_i = 1'b0;
    data_sram_data_ok_i = 1'b1;
    data_sram_rdata_i   = 32'h12345678;
    #1;
    n_chk++;
    if (mem_data_ok_o !== 1'b0) begin
      n_fail++;
      $display("FAIL buf_early got %0b exp 0", mem_data_ok_o);
    end
    @(negedge clk);
    data_sram_data_ok_i = 1'b0;
    data_sram_rdata_i   = 32'hFFFF0000;
    mem_allowin_i       = 1'b1;
    #1;
    n_chk++;
    if (mem_data_ok_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL buf_hold got dok=%0b busy=%0b exp 0 0",
               mem_data_ok_o, busy_o);
    end
    @(negedge clk);
    idle();
    mem_wait_i = 1'b1;
    #1;
    n_chk++;
    if (mem_data_ok_o !== 1'b1 || mem_rdata_o !== 32'h12345678) begin
      n_fail++;
      $display("FAIL buf_out got %0b/%h exp 1/12345678",
               mem_data_ok_o, mem_rdata_o);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (mem_data_ok_o !== 1'b0) begin
      n_fail++;
      $display("FAIL buf_once got %0b exp 0", mem_data_ok_o);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    load(32'h5000);
    data_sram_addr_ok_i = 1'b1;
    @(negedge clk);
    load(32'h5004);
    mem_allowin_i = 1'b0;
    mem_wait_i    = 1'b1;
    @(negedge clk);
    data_sram_addr_ok_i = 1'b0;
    data_sram_data_ok_i = 1'b1;
    data_sram_rdata_i   = 32'hAB;
    mem_wait_i          = 1'b0;
    @(negedge clk);
    data_sram_data_ok_i = 1'b0;
    #1;
    n_chk++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_setup got busy=%0b exp 1", busy_o);
    end
    rst_n = 1'b1;
    mem_wait_i = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if ({data_sram_req_o, ex_ready_go_o, mem_data_ok_o, busy_o,
         mem_rdata_o} !== 36'd0) begin
      n_fail++;
      $display("FAIL rm_outs got req=%0b rdy=%0b dok=%0b busy=%0b rd=%h exp 0",
               data_sram_req_o, ex_ready_go_o, mem_data_ok_o, busy_o,
               mem_rdata_o);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    mem_wait_i = 1'b1;
    #1;
    n_chk++;
    if ({mem_data_ok_o, busy_o, ex_ready_go_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL rm_clear got dok=%0b busy=%0b rdy=%0b exp 0 0 1",
               mem_data_ok_o, busy_o, ex_ready_go_o);
    end
    @(negedge clk);
    idle();
  endtask

  // MEM always waits and always allows in, so every response that is not
  // cancelled must reach MEM the same cycle, in issue order.
  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    logic        exp_req;
    logic        exp_rdy;
    logic        exp_dok;
    logic [3:0]  exp_ws;
    logic [31:0] a;
    int          sz;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      idle();
      sz = $urandom_range(0, 2);
      a  = $urandom;
      a  = a & ~((32'd1 << sz) - 32'd1);
      ex_req_valid_i      = ($urandom % 4) != 0;
      ex_wr_i             = $urandom % 2;
      ex_size_i           = 2'(sz);
      ex_addr_i           = a;
      ex_wdata_i          = $urandom;
      mem_wait_i          = 1'b1;
      excep_flush_i       = ($urandom % 12) == 0;
      data_sram_addr_ok_i = $urandom % 2;
      data_sram_data_ok_i = (q.size() > 0) && ($urandom % 2 == 1);
      data_sram_rdata_i   = q.size() > 0 ? q[0].data : 32'h0;
      #1;
      exp_req = ex_req_valid_i & ~excep_flush_i & (q.size() < 2);
      exp_rdy = ~ex_req_valid_i | (exp_req & data_sram_addr_ok_i);
      exp_dok = data_sram_data_ok_i && !q[0].cancel;
      exp_ws  = ex_wr_i ? 4'(((1 << (1 << sz)) - 1) << a[1:0]) : 4'd0;
      n_chk++;
      if (data_sram_req_o !== exp_req || ex_ready_go_o !== exp_rdy) begin
        n_fail++;
        $display("FAIL rnd_req c=%0d got req=%0b rdy=%0b exp %0b %0b",
                 c, data_sram_req_o, ex_ready_go_o, exp_req, exp_rdy);
      end
      n_chk++;
      if (data_sram_wstrb_o !== exp_ws || data_sram_addr_o !== a) begin
        n_fail++;
        $display("FAIL rnd_strb c=%0d got %b/%h exp %b/%h",
                 c, data_sram_wstrb_o, data_sram_addr_o, exp_ws, a);
      end
      n_chk++;
      if (busy_o !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd_busy c=%0d got %0b exp %0b",
                 c, busy_o, q.size() != 0);
      end
      n_chk++;
      if (mem_data_ok_o !== exp_dok ||
          (exp_dok && mem_rdata_o !== q[0].data)) begin
        n_fail++;
        $display("FAIL rnd_resp c=%0d got %0b/%h exp %0b/%h",
                 c, mem_data_ok_o, mem_rdata_o, exp_dok,
                 q.size() > 0 ? q[0].data : 32'h0);
      end
      if (data_sram_data_ok_i)
        void'(q.pop_front());
      if (excep_flush_i)
        foreach (q[i]) q[i].cancel = 1'b1;
      if (exp_req && data_sram_addr_ok_i) begin
        e.data   = $urandom;
        e.cancel = 1'b0;
        q.push_back(e);
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    test_reset();
    test_load_word();
    test_store_stall();
    test_flush_cancel();
    test_back_to_back();
    test_buffer();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
